// File: rtl/run_seq_pkg.sv
// Shared types and defaults for the run sequencer and its bench.
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        ASSERT,
        WAIT_ACK,
        REPORT,
        DONE
    } run_state_t;

    localparam int TIMEOUT_DEF = 4096;
    localparam int CNT_W_DEF   = 16;

    // A single-run batch still needs a 1-bit run index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max flags value == MAX.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] value,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (en && (value != MAX_V))
            value <= value + 1'b1;
    end

    assign at_max = (value == MAX_V);

endmodule

// File: rtl/run_sequencer.sv
// Drives the DUT reset/start/ack handshake for a batch of runs and reports per-run cycle counts.
// Optional RUN_SEQ_STATS_EN adds total_cycles / max_cycles batch statistics.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int NUM_RUNS   = 3,
    parameter int RST_CYCLES = 2,
    parameter int START_HOLD = 2,
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    localparam int IDX_W     = idx_w(NUM_RUNS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    output logic             dut_reset,
    output logic             start,
    input  logic             ack,
    output logic             busy,
    output logic [IDX_W-1:0] run_idx,
    output logic [CNT_W-1:0] cycles,
    output logic             cycles_valid,
    output logic             timed_out,
    output logic             batch_done
`ifdef RUN_SEQ_STATS_EN
    ,
    output logic [CNT_W+$clog2(NUM_RUNS):0] total_cycles,
    output logic [CNT_W-1:0]                max_cycles
`endif
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(START_HOLD + 1);

    run_state_t       state;
    logic [RW-1:0]    unused_rst_cnt;
    logic [SW-1:0]    unused_st_cnt;
    logic             rst_last;
    logic             st_last;
    logic [CNT_W-1:0] cnt;
    logic             cnt_max;
    logic             wait_en;

    sat_counter #(.WIDTH(RW), .MAX(RST_CYCLES - 1)) u_rst_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != DUT_RST),
        .en      (state == DUT_RST),
        .value   (unused_rst_cnt),
        .at_max  (rst_last)
    );

    sat_counter #(.WIDTH(SW), .MAX(START_HOLD - 1)) u_st_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != ASSERT),
        .en      (state == ASSERT),
        .value   (unused_st_cnt),
        .at_max  (st_last)
    );

    // Counting begins on the last ASSERT cycle so cnt reads 1 in the first WAIT_ACK cycle.
    assign wait_en = (state == WAIT_ACK) || ((state == ASSERT) && st_last);

    sat_counter #(.WIDTH(CNT_W), .MAX(TIMEOUT)) u_wait_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (!wait_en),
        .en      (wait_en),
        .value   (cnt),
        .at_max  (cnt_max)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            dut_reset    <= 1'b0;
            start        <= 1'b0;
            busy         <= 1'b0;
            run_idx      <= '0;
            cycles       <= '0;
            cycles_valid <= 1'b0;
            timed_out    <= 1'b0;
            batch_done   <= 1'b0;
        end else begin
            cycles_valid <= 1'b0;
            batch_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state     <= DUT_RST;
                        run_idx   <= '0;
                        busy      <= 1'b1;
                        dut_reset <= 1'b1;
                    end
                end
                DUT_RST: begin
                    if (rst_last) begin
                        state     <= ASSERT;
                        dut_reset <= 1'b0;
                        start     <= 1'b1;
                    end
                end
                ASSERT: begin
                    if (st_last) begin
                        state <= WAIT_ACK;
                        start <= 1'b0;
                    end
                end
                WAIT_ACK: begin
                    // cnt equals TIMEOUT on expiry, so it is the reported count either way.
                    if (ack || cnt_max) begin
                        state        <= REPORT;
                        cycles       <= cnt;
                        timed_out    <= !ack;
                        cycles_valid <= 1'b1;
                    end
                end
                REPORT: begin
                    if (run_idx == IDX_W'(NUM_RUNS - 1)) begin
                        state      <= DONE;
                        batch_done <= 1'b1;
                    end else begin
                        state     <= DUT_RST;
                        run_idx   <= run_idx + 1'b1;
                        dut_reset <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RUN_SEQ_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total_cycles <= '0;
            max_cycles   <= '0;
        end else if ((state == IDLE) && go) begin
            total_cycles <= '0;
            max_cycles   <= '0;
        end else if (state == REPORT) begin
            total_cycles <= total_cycles + ($bits(total_cycles))'(cycles);
            if (cycles > max_cycles)
                max_cycles <= cycles;
        end
    end
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench: instance 0 uses the default TIMEOUT, instance 1 uses TIMEOUT=16.
module tb_run_sequencer;
    import run_seq_pkg::*;

    localparam int NR   = 3;
    localparam int RC   = 2;
    localparam int SH   = 2;
    localparam int TO_S = 16;
    localparam int IW   = $clog2(NR);

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      go;
    logic            dut_reset[2];
    logic            start[2];
    logic            busy[2];
    logic            cycles_valid[2];
    logic            timed_out[2];
    logic            batch_done[2];
    logic [IW-1:0]   run_idx[2];
    logic [CNT_W_DEF-1:0] cycles[2];
`ifdef RUN_SEQ_STATS_EN
    logic [CNT_W_DEF+IW:0]  total_cycles[2];
    logic [CNT_W_DEF-1:0]   max_cycles[2];
`endif

    typedef struct {
        int idx;
        int cyc;
        bit to;
    } rpt_t;

    rpt_t exp_q[$];
    int   dly_q[2][$];
    bit   early[2];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    int   last_rpt[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic ack;
        int   rlen;
        int   slen;
        bit   pstart;

        run_sequencer #(
            .NUM_RUNS   (NR),
            .RST_CYCLES (RC),
            .START_HOLD (SH),
            .TIMEOUT    ((g == 0) ? TIMEOUT_DEF : TO_S),
            .CNT_W      (CNT_W_DEF)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .go           (go[g]),
            .dut_reset    (dut_reset[g]),
            .start        (start[g]),
            .ack          (ack),
            .busy         (busy[g]),
            .run_idx      (run_idx[g]),
            .cycles       (cycles[g]),
            .cycles_valid (cycles_valid[g]),
            .timed_out    (timed_out[g]),
            .batch_done   (batch_done[g])
`ifdef RUN_SEQ_STATS_EN
            ,
            .total_cycles (total_cycles[g]),
            .max_cycles   (max_cycles[g])
`endif
        );

        // DUT model: ack rises d cycles after start falls (d=0: never); early=1 holds ack during reset.
        initial begin
            int d;
            ack    = 1'b0;
            pstart = 1'b0;
            forever begin
                @(negedge clk);
                if (dut_reset[g]) begin
                    ack = early[g];
                end else if (pstart && !start[g] && reset_n) begin
                    ack = 1'b0;
                    d = (dly_q[g].size() > 0) ? dly_q[g].pop_front() : 0;
                    if (d > 0) begin
                        repeat (d - 1) @(negedge clk);
                        ack = 1'b1;
                    end
                end
                pstart = start[g];
            end
        end

        // Report scoreboard plus pulse-width checks on dut_reset and start.
        initial begin
            rpt_t e;
            rlen = 0;
            slen = 0;
            forever begin
                @(negedge clk);
                if (cycles_valid[g]) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("extra_rpt%0d", g), 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("rpt_idx%0d", g), run_idx[g], e.idx);
                        chk($sformatf("rpt_cyc%0d", g), cycles[g], e.cyc);
                        chk($sformatf("rpt_to%0d", g), timed_out[g], e.to);
                    end
                    last_rpt[g] = cyc_n;
                end
                if (dut_reset[g]) rlen++;
                else begin
                    if (rlen > 0) chk($sformatf("rst_len%0d", g), rlen, RC);
                    rlen = 0;
                end
                if (start[g]) slen++;
                else begin
                    if (slen > 0) chk($sformatf("start_len%0d", g), slen, SH);
                    slen = 0;
                end
                if (dut_reset[g] && start[g]) chk($sformatf("rst_start_ovl%0d", g), 1, 0);
            end
        end
    end

    task automatic push_run(input int g, input int idx, input int d, input int cyc, input bit to);
        dly_q[g].push_back(d);
        exp_q.push_back('{idx, cyc, to});
    endtask

    task automatic run_batch(input int g, input bit extra_go);
        int n;
        n = 0;
        @(negedge clk);
        go[g] = 1'b1;
        @(negedge clk);
        go[g] = 1'b0;
        if (extra_go) begin
            repeat (3) @(negedge clk);
            go[g] = 1'b1;
            @(negedge clk);
            go[g] = 1'b0;
            chk("busy_hold", busy[g], 1);
        end
        while (!batch_done[g] && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("bdone_seen", batch_done[g], 1);
        if (batch_done[g]) chk("bdone_lat", cyc_n - last_rpt[g], 1);
        chk("q_empty", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        go      = 2'b11;
        #12;
        for (int g = 0; g < 2; g++)
            chk($sformatf("rst_outs%0d", g),
                {dut_reset[g], start[g], busy[g], run_idx[g], cycles[g],
                 cycles_valid[g], timed_out[g], batch_done[g]}, 0);
        go = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy[0], 0);
        chk("idle_dut_reset", dut_reset[0], 0);

        // Nominal batch, with a stray go while busy.
        push_run(0, 0, 10, 10, 0);
        push_run(0, 1, 20, 20, 0);
        push_run(0, 2, 5, 5, 0);
        run_batch(0, 1'b1);
`ifdef RUN_SEQ_STATS_EN
        chk("total_cycles", total_cycles[0], 35);
        chk("max_cycles", max_cycles[0], 20);
`endif
        @(negedge clk);
        chk("busy_clr", busy[0], 0);

        // Timeout, tie at TIMEOUT, then a normal run.
        push_run(1, 0, 0, TO_S, 1);
        push_run(1, 1, TO_S, TO_S, 0);
        push_run(1, 2, 3, 3, 0);
        run_batch(1, 1'b0);

        // Sticky ack through DUT_RST/ASSERT is ignored.
        early[0] = 1'b1;
        push_run(0, 0, 3, 3, 0);
        push_run(0, 1, 3, 3, 0);
        push_run(0, 2, 7, 7, 0);
        run_batch(0, 1'b0);
        early[0] = 1'b0;

        // Mid-run reset during WAIT_ACK.
        dly_q[0].push_back(12);
        @(negedge clk);
        go[0] = 1'b1;
        @(negedge clk);
        go[0] = 1'b0;
        n = 0;
        while (!start[0] && n < 50) begin @(negedge clk); n++; end
        while (start[0] && n < 50) begin @(negedge clk); n++; end
        chk("mid_reach_wait", n < 50, 1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_start", start[0], 0);
        chk("mid_dut_reset", dut_reset[0], 0);
        chk("mid_busy", busy[0], 0);
        chk("mid_valid", cycles_valid[0], 0);
        repeat (15) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh batch after the abort restarts at run 0.
        push_run(0, 0, 4, 4, 0);
        push_run(0, 1, 6, 6, 0);
        push_run(0, 2, 8, 8, 0);
        run_batch(0, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
